// File: rtl/counter_sequencer.sv
// Start/stop/hold sequencer for a WIDTH-bit up-counter with a prescaler,
// programmable terminal value and one-shot or auto-reload mode.
module counter_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             reload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, lim_q, lim_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             mode_q, mode_d, busy_q, busy_d, done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      lim_q   <= '0;
      presc_q <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      lim_q   <= lim_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Priority: stop > start/restart > counting (hold freezes the counting path)
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    lim_d   = lim_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      q_d     = '0;
      presc_d = '0;
    end else if (start) begin
      if (limit != '0) begin
        state_d = RUN;
        lim_d   = limit;
        mode_d  = reload;
        q_d     = '0;
        presc_d = '0;
      end else if (state_q == RUN) begin
        // restart with a zero limit aborts the run
        state_d = IDLE;
        q_d     = '0;
        presc_d = '0;
      end
    end else if (state_q == RUN && !hold) begin
      if (presc_q == PLAST) begin
        presc_d = '0;
        if (q_q == lim_q) begin
          q_d    = '0;
          done_d = 1'b1;
          if (!mode_q) state_d = IDLE;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    busy_d = (state_d == RUN);
  end

  always_comb begin
    q    = q_q;
    busy = busy_q;
    done = done_q;
  end
endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: two instances (PRESCALE 1 and 3)
// checked every cycle against an elapsed-time model plus literal expectations.
module tb_counter_sequencer;
  logic       clk = 1'b0;
  logic       reset, start, stop, hold, reload;
  logic [3:0] limit;
  logic [3:0] q1, q3;
  logic       busy1, busy3, done1, done3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(4), .PRESCALE(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .hold(hold),
    .reload(reload), .limit(limit), .q(q1), .busy(busy1), .done(done1));

  counter_sequencer #(.WIDTH(4), .PRESCALE(3)) u3 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .hold(hold),
    .reload(reload), .limit(limit), .q(q3), .busy(busy3), .done(done3));

  // Model: a run is described by its unheld elapsed cycles t; the count is
  // the number of completed prescale periods modulo (limit+1).
  int  mp[2] = '{1, 3};
  bit  mrun[2], mmode[2], mdone[2];
  int  mt[2], mlim[2], mq[2];
  bit  mvalid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mdone[i] = 1'b0;
      if (reset) begin
        mrun[i] = 1'b0; mt[i] = 0; mlim[i] = 0; mmode[i] = 1'b0;
      end else if (stop) begin
        mrun[i] = 1'b0; mt[i] = 0;
      end else if (start) begin
        if (limit != 0) begin
          mrun[i] = 1'b1; mlim[i] = limit; mmode[i] = reload; mt[i] = 0;
        end else begin
          mrun[i] = 1'b0; mt[i] = 0;
        end
      end else if (mrun[i] && !hold) begin
        mt[i]++;
        if (mt[i] % mp[i] == 0 && (mt[i] / mp[i]) % (mlim[i] + 1) == 0) begin
          mdone[i] = 1'b1;
          if (!mmode[i]) begin mrun[i] = 1'b0; mt[i] = 0; end
        end
      end
      mq[i] = mrun[i] ? (mt[i] / mp[i]) % (mlim[i] + 1) : 0;
    end
    if (reset) mvalid = 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m1.q", q1, mq[0]);
      chk("m1.busy", busy1, mrun[0]);
      chk("m1.done", done1, mdone[0]);
      chk("m3.q", q3, mq[1]);
      chk("m3.busy", busy3, mrun[1]);
      chk("m3.done", done3, mdone[1]);
    end
  end

  // drive at negedge, return #1 after the following posedge
  task automatic step(input logic rs, st, sp, hd, rl, input logic [3:0] lm);
    @(negedge clk);
    reset = rs; start = st; stop = sp; hold = hd; reload = rl; limit = lm;
    @(posedge clk); #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, reload, limit);
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; hold = 0; reload = 0; limit = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1, 4'd9);
    chk("rst.q", q1, 0); chk("rst.busy", busy1, 0); chk("rst.done", done1, 0);

    // one-shot, limit 3
    step(0, 1, 0, 0, 0, 4'd3);
    chk("os.e0.q", q1, 0); chk("os.e0.busy", busy1, 1);
    idle_n(3);
    chk("os.e3.q", q1, 3); chk("os.e3.busy", busy1, 1); chk("os.e3.done", done1, 0);
    idle_n(1);
    chk("os.e4.q", q1, 0); chk("os.e4.done", done1, 1); chk("os.e4.busy", busy1, 0);
    idle_n(1);
    chk("os.e5.done", done1, 0); chk("os.e5.busy", busy1, 0);

    // auto-reload, limit 2, then stop
    step(0, 1, 0, 0, 1, 4'd2);
    idle_n(3);
    chk("ar.e3.done", done1, 1); chk("ar.e3.q", q1, 0); chk("ar.e3.busy", busy1, 1);
    idle_n(2);
    chk("ar.e5.q", q1, 2); chk("ar.e5.done", done1, 0);
    idle_n(1);
    chk("ar.e6.done", done1, 1);
    idle_n(3);
    chk("ar.e9.done", done1, 1);
    step(0, 0, 1, 0, 1, 4'd2);
    chk("stop.q", q1, 0); chk("stop.busy", busy1, 0); chk("stop.done", done1, 0);

    // prescale 3, limit 1, one-shot
    step(0, 1, 0, 0, 0, 4'd1);
    idle_n(2);
    chk("ps.e2.q", q3, 0);
    idle_n(1);
    chk("ps.e3.q", q3, 1); chk("ps.e3.busy", busy3, 1);
    idle_n(3);
    chk("ps.e6.q", q3, 0); chk("ps.e6.done", done3, 1); chk("ps.e6.busy", busy3, 0);

    // hold for 4 cycles at q=2, limit 5
    step(0, 1, 0, 0, 0, 4'd5);
    idle_n(2);
    chk("hd.e2.q", q1, 2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 4'd5);
    chk("hd.e6.q", q1, 2); chk("hd.e6.done", done1, 0); chk("hd.e6.busy", busy1, 1);
    idle_n(3);
    chk("hd.e9.q", q1, 5);
    idle_n(1);
    chk("hd.e10.done", done1, 1); chk("hd.e10.busy", busy1, 0);

    // start+stop, start with zero limit
    step(0, 1, 0, 0, 1, 4'd6);
    idle_n(2);
    step(0, 1, 1, 0, 1, 4'd6);
    chk("ss.q", q1, 0); chk("ss.busy", busy1, 0);
    step(0, 1, 0, 0, 0, 4'd0);
    chk("z.busy", busy1, 0); chk("z.q", q1, 0); chk("z.done", done1, 0);

    // restart on the terminal edge uses the new limit
    step(0, 1, 0, 0, 0, 4'd2);
    idle_n(2);
    chk("rs.e2.q", q1, 2);
    step(0, 1, 0, 0, 0, 4'd4);
    chk("rs.q", q1, 0); chk("rs.done", done1, 0); chk("rs.busy", busy1, 1);
    idle_n(4);
    chk("rs.q4", q1, 4); chk("rs.done4", done1, 0);
    idle_n(1);
    chk("rs.done5", done1, 1);

    // restart with zero limit while running aborts
    step(0, 1, 0, 0, 1, 4'd7);
    idle_n(2);
    step(0, 1, 0, 0, 1, 4'd0);
    chk("rz.busy", busy1, 0); chk("rz.q", q1, 0);

    // reset mid-run overrides start
    step(0, 1, 0, 0, 1, 4'd15);
    idle_n(7);
    chk("rm.q7", q1, 7);
    step(1, 1, 0, 0, 1, 4'd15);
    chk("rm.q", q1, 0); chk("rm.busy", busy1, 0); chk("rm.done", done1, 0);

    // full-range wrap
    step(0, 1, 0, 0, 1, 4'd15);
    idle_n(15);
    chk("fw.q15", q1, 15);
    idle_n(1);
    chk("fw.q0", q1, 0); chk("fw.done", done1, 1); chk("fw.busy", busy1, 1);
    idle_n(1);
    chk("fw.q1", q1, 1); chk("fw.done1", done1, 0);
    step(0, 0, 1, 0, 0, 4'd0);
    idle_n(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
